eth_ip_filter: RTL and testbench
================================

// Module: eth_ip_filter
// PURPOSE
//  Consumes ethernet_parser's AXI-Stream output and its parsed-header sideband.
//  Holds each frame in a store-until-decided word FIFO and matches (dst_ip, dst_port)
//  against a small programmable allow table. Each whole frame is forwarded or silently
//  dropped. Sits directly downstream of ethernet_parser; feeds the egress MAC/DMA stage.
// PARAMETERS
//  DATA_W      64  stream data width (KEEP_W = DATA_W/8)
//  FIFO_DEPTH  32  data FIFO depth in words; power of 2, >= 8
//  DEC_DEPTH   4   decision FIFO depth (frames resident at once); power of 2
//  N_RULES     4   allow-table entries
//  DEC_LIMIT   6   ingress words without parsed_valid_pulse before forced drop
// PORTS
//  clk                 in   1       clock
//  rst                 in   1       synchronous reset, active-high
//  s_axis_tdata        in   DATA_W  frame data from parser
//  s_axis_tkeep        in   KEEP_W  byte enables
//  s_axis_tvalid/tlast in   1       AXIS valid / end of frame
//  s_axis_tready       out  1       ingress ready
//  parsed_valid_pulse  in   1       1-cycle pulse: header fields below are valid
//  ethertype           in   16      parsed ethertype
//  dst_ip              in   32      parsed IPv4 destination
//  dst_port            in   16      parsed L4 destination port
//  cfg_we              in   1       allow-table write strobe
//  cfg_idx             in   $clog2(N_RULES)  entry index
//  cfg_en              in   1       entry enable
//  cfg_dst_ip          in   32      entry IP
//  cfg_dst_port        in   16      entry port; 0 = wildcard
//  m_axis_tdata/tkeep  out  DATA_W/KEEP_W  forwarded frame
//  m_axis_tvalid/tlast out  1       egress valid / end of frame
//  m_axis_tready       in   1       egress ready
//  pass_cnt, drop_cnt  out  32      frames forwarded / dropped; saturate at 2^32-1
// BEHAVIOUR
//  Reset: FIFOs empty; table entries disabled; FSM IDLE.
//   m_axis_tvalid=0, tdata/tkeep/tlast=0, s_axis_tready=0 in the reset cycle; counters=0.
//  Ingress: word is accepted on s_axis_tvalid & s_axis_tready.
//   s_axis_tready = !data_full & !(at_frame_start & dec_full).
//   Per-frame word counter; frame ends on accepted tlast.
//  Decision: exactly one per frame, pushed to decision FIFO as {pass}.
//   - parsed_valid_pulse while frame open and undecided: registered compare.
//     Decision pushed the next cycle.
//     pass = (ethertype==16'h0800) & any enabled entry with ip==dst_ip
//     & (port==0 | port==dst_port).
//   - Frame ends (tlast) or word count reaches DEC_LIMIT, still undecided: push drop.
//   - Pulse in same cycle as tlast: pulse wins. Pulse after frame decided: ignored.
//   - Table write in same cycle as compare: compare uses the old entry.
//  Egress FSM: IDLE -> (dec not empty) FWD if pass else DROP.
//   FWD: drive FIFO head; pop on m_axis_tready; on popped tlast -> IDLE, pop dec, pass_cnt++.
//   DROP: pop one word/cycle, m_axis_tvalid=0; on tlast -> IDLE, pop dec, drop_cnt++.
//   Min latency s_axis word 0 -> m_axis word 0: decision cycle + 2.
//   Data and keep passed bit-exact; no bubbles within a frame when m_axis_tready=1.
//  Frames longer than FIFO_DEPTH are legal: decision made by DEC_LIMIT < FIFO_DEPTH,
//   so egress drains while ingress fills.
//  m_axis outputs held stable while tvalid & !tready (AXIS rule).
//  Reset mid-frame: all partial frames discarded; counters cleared; table cleared.
// STRUCTURE
//  eth_pkg: ETHERTYPE_IPV4=16'h0800, rule_t {en, ip[31:0], port[15:0]}, egress state enum.
//  Sub-module: sync_fifo (parameterised width/depth, show-ahead).
//   Instanced twice: data {last,keep,data}, decision {pass}.
//  Match logic, counters and FSM live in the top.
// TESTING
//  1. Table[0]={1,C0A80002,9C40}; send 6-word UDP frame
//     (words 001122334455_6677..DEADBEEF00000000, last keep=0F), pulse with
//     dst_ip=C0A80002, dst_port=9C40 -> same 6 words/keeps out, tlast on 6th, pass_cnt=1.
//  2. Same frame, table empty -> m_axis_tvalid never 1, drop_cnt=1, s_axis_tready stays 1.
//  3. Table[1]={1,C0A80002,0000} wildcard; frame with dst_port=1F90 -> forwarded, pass_cnt=1.
//  4. Pass frame back-to-back with drop frame, m_axis_tready toggling 1/0 each cycle
//     -> only first frame out, data stable across stalls, pass=1 drop=1.
//  5. 3-word frame, no pulse -> dropped at tlast; 40-word non-IP frame, no pulse
//     -> dropped after word 6, no deadlock, drop_cnt=2.
//  6. rst=1 at word 3 of a passing frame -> m_axis_tvalid=0 next cycle, counters 0;
//     a following frame passes only after table reprogrammed.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types for the IPv4 destination filter: the allow-table entry, the
// egress state encoding and the rule match helper.
package eth_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

  typedef struct packed {
    logic        en;
    logic [31:0] ip;
    logic [15:0] port;
  } rule_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_DROP
  } egr_state_t;

  // A port of zero in the entry matches any destination port.
  function automatic logic rule_hit(input rule_t r, input logic [31:0] ip,
                                    input logic [15:0] port);
    return r.en && (r.ip == ip) && ((r.port == 16'h0000) || (r.port == port));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: the head entry is visible on o_rd_data whenever
// o_empty is low, and i_rd_en pops it.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr_en,
  input  logic [WIDTH-1:0]       i_wr_data,
  input  logic                   i_rd_en,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_do_wr;
  logic             w_do_rd;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (o_count == (AW+1)'(DEPTH));
  assign w_do_wr   = i_wr_en & ~w_full;
  assign w_do_rd   = i_rd_en & ~o_empty;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: the storage array has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/eth_ip_filter.sv
// Store-until-decided frame filter: buffers each ingress frame, matches its parsed
// (dst_ip, dst_port) against a programmable allow table, then forwards or drops it whole.
module eth_ip_filter
  import eth_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 32,
  parameter int DEC_DEPTH  = 4,
  parameter int N_RULES    = 4,
  parameter int DEC_LIMIT  = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          s_axis_tdata,
  input  logic [DATA_W/8-1:0]        s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  input  logic                       parsed_valid_pulse,
  input  logic [15:0]                ethertype,
  input  logic [31:0]                dst_ip,
  input  logic [15:0]                dst_port,
  input  logic                       cfg_we,
  input  logic [$clog2(N_RULES)-1:0] cfg_idx,
  input  logic                       cfg_en,
  input  logic [31:0]                cfg_dst_ip,
  input  logic [15:0]                cfg_dst_port,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic [DATA_W/8-1:0]        m_axis_tkeep,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  output logic [31:0]                pass_cnt,
  output logic [31:0]                drop_cnt
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int DW     = 1 + KEEP_W + DATA_W;
  localparam int CW     = $clog2(DEC_LIMIT + 1);
  localparam int FCW    = $clog2(FIFO_DEPTH) + 1;
  localparam int DCW    = $clog2(DEC_DEPTH) + 1;

  rule_t            r_table [N_RULES];
  logic             r_in_frame;
  logic             r_decided;
  logic [CW-1:0]    r_wcnt;
  logic             r_push;
  logic             r_push_pass;
  egr_state_t       r_state;
  logic [31:0]      r_pass_cnt;
  logic [31:0]      r_drop_cnt;

  logic             w_accept;
  logic             w_data_full;
  logic             w_dec_full;
  logic             w_match;
  logic             w_take_pulse;
  logic             w_force_drop;
  logic [CW-1:0]    w_wcnt_next;
  logic [DW-1:0]    w_head;
  logic             w_data_empty;
  logic [FCW-1:0]   w_data_count;
  logic             w_dec_head;
  logic             w_dec_empty;
  logic [DCW-1:0]   w_dec_count;
  logic [DCW:0]     w_dec_occ;
  logic             w_m_valid;
  logic             w_data_pop;
  logic             w_frame_done;

  // ---------------- ingress ----------------
  // A decision still sitting in r_push already owns a decision FIFO slot.
  assign w_dec_occ     = (DCW+1)'(w_dec_count) + (DCW+1)'(r_push);
  assign w_dec_full    = (w_dec_occ >= (DCW+1)'(DEC_DEPTH));
  assign w_data_full   = (w_data_count == FCW'(FIFO_DEPTH));
  assign s_axis_tready = ~rst & ~w_data_full & ~(~r_in_frame & w_dec_full);
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign w_wcnt_next   = r_wcnt + CW'(1);

  // NOTE: combinational outputs get a default before any conditional so no latch is inferred.
  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < N_RULES; i++) begin
      if (rule_hit(r_table[i], dst_ip, dst_port)) w_match = 1'b1;
    end
  end

  // The pulse beats a same-cycle tlast or word-limit drop.
  assign w_take_pulse = parsed_valid_pulse & ~r_decided & (r_in_frame | w_accept);
  assign w_force_drop = w_accept & ~r_decided & ~w_take_pulse &
                        (s_axis_tlast | (w_wcnt_next == CW'(DEC_LIMIT)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_frame  <= 1'b0;
      r_decided   <= 1'b0;
      r_wcnt      <= '0;
      r_push      <= 1'b0;
      r_push_pass <= 1'b0;
    end else begin
      r_push      <= w_take_pulse | w_force_drop;
      r_push_pass <= w_take_pulse & (ethertype == ETHERTYPE_IPV4) & w_match;
      if (w_accept) r_in_frame <= ~s_axis_tlast;
      if (w_accept & s_axis_tlast) begin
        r_decided <= 1'b0;
        r_wcnt    <= '0;
      end else begin
        if (w_take_pulse | w_force_drop) r_decided <= 1'b1;
        if (w_accept && (r_wcnt < CW'(DEC_LIMIT))) r_wcnt <= w_wcnt_next;
      end
    end
  end

  // Writes land at the clock edge, so a same-cycle compare sees the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_RULES; i++) r_table[i] <= '0;
    end else if (cfg_we) begin
      r_table[cfg_idx] <= {cfg_en, cfg_dst_ip, cfg_dst_port};
    end
  end

  sync_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_accept),
    .i_wr_data ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .i_rd_en   (w_data_pop),
    .o_rd_data (w_head),
    .o_empty   (w_data_empty),
    .o_count   (w_data_count)
  );

  sync_fifo #(.WIDTH(1), .DEPTH(DEC_DEPTH)) u_dec_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (r_push),
    .i_wr_data (r_push_pass),
    .i_rd_en   (w_frame_done),
    .o_rd_data (w_dec_head),
    .o_empty   (w_dec_empty),
    .o_count   (w_dec_count)
  );

  // ---------------- egress ----------------
  assign w_m_valid    = (r_state == ST_FWD) & ~w_data_empty;
  assign w_data_pop   = (w_m_valid & m_axis_tready) | ((r_state == ST_DROP) & ~w_data_empty);
  assign w_frame_done = w_data_pop & w_head[DW-1];

  assign m_axis_tvalid = ~rst & w_m_valid;
  assign m_axis_tdata  = m_axis_tvalid ? w_head[DATA_W-1:0]      : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? w_head[DATA_W +: KEEP_W] : '0;
  assign m_axis_tlast  = m_axis_tvalid & w_head[DW-1];
  assign pass_cnt      = r_pass_cnt;
  assign drop_cnt      = r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pass_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (!w_dec_empty) r_state <= w_dec_head ? ST_FWD : ST_DROP;
        ST_FWD: if (w_frame_done) begin
          r_state <= ST_IDLE;
          if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + 32'd1;
        end
        ST_DROP: if (w_frame_done) begin
          r_state <= ST_IDLE;
          if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 32'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_ip_filter.sv
// Randomised scoreboard bench for eth_ip_filter: a frame-level model predicts which
// frames come out, and an independent monitor checks every egress word against it.
module tb_eth_ip_filter;

  localparam int DATA_W    = 64;
  localparam int DEC_LIMIT = 6;
  localparam int N_RULES   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [63:0]       s_axis_tdata = '0;
  logic [7:0]        s_axis_tkeep = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tready;
  logic              parsed_valid_pulse = 1'b0;
  logic [15:0]       ethertype = '0;
  logic [31:0]       dst_ip = '0;
  logic [15:0]       dst_port = '0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_idx = '0;
  logic              cfg_en = 1'b0;
  logic [31:0]       cfg_dst_ip = '0;
  logic [15:0]       cfg_dst_port = '0;
  logic [63:0]       m_axis_tdata;
  logic [7:0]        m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready = 1'b1;
  logic [31:0]       pass_cnt;
  logic [31:0]       drop_cnt;

  eth_ip_filter dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .parsed_valid_pulse(parsed_valid_pulse), .ethertype(ethertype),
    .dst_ip(dst_ip), .dst_port(dst_port),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_dst_ip(cfg_dst_ip), .cfg_dst_port(cfg_dst_port),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .pass_cnt(pass_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [72:0] exp_q[$];
  int          mdl_pass = 0;
  int          mdl_drop = 0;
  logic        m_en [N_RULES];
  logic [31:0] m_ip [N_RULES];
  logic [15:0] m_port [N_RULES];
  logic [63:0] fd[$];
  logic [7:0]  fk[$];
  int          rdy_mode = 0;
  logic        prev_stall = 1'b0;
  logic [72:0] prev_word = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Egress monitor: AXIS hold rule plus in-order comparison with the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("egress hold", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata},
              {1'b1, prev_word});
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) check("egress with empty queue", m_axis_tvalid, 1'b0);
        else check("egress word", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, exp_q.pop_front());
      end
      prev_stall = m_axis_tvalid & ~m_axis_tready;
      prev_word  = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'($urandom_range(1));
      endcase
    end
  end

  function automatic logic allowed(input logic [15:0] et, input logic [31:0] ip,
                                   input logic [15:0] port);
    logic hit = 1'b0;
    for (int i = 0; i < N_RULES; i++)
      if (m_en[i] && m_ip[i] == ip && (m_port[i] == 16'h0 || m_port[i] == port)) hit = 1'b1;
    return hit && (et == 16'h0800);
  endfunction

  task automatic clear_model();
    exp_q.delete();
    mdl_pass = 0;
    mdl_drop = 0;
    for (int i = 0; i < N_RULES; i++) begin
      m_en[i] = 1'b0; m_ip[i] = '0; m_port[i] = '0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_model();
  endtask

  task automatic cfg(input int idx, input logic en, input logic [31:0] ip, input logic [15:0] port);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_en = en; cfg_dst_ip = ip; cfg_dst_port = port;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_en[idx] = en; m_ip[idx] = ip; m_port[idx] = port;
  endtask

  task automatic build_random(input int len);
    fd.delete(); fk.delete();
    for (int i = 0; i < len; i++) begin
      fd.push_back({$urandom, $urandom});
      fk.push_back(i == len - 1 ? (8'hFF >> $urandom_range(7)) : 8'hFF);
    end
  endtask

  task automatic build_udp();
    fd = '{64'h0011223344556677, 64'h8899AABBCCDDEEFF, 64'h08004500002E0000,
           64'h40001140C0A80001, 64'hC0A80002AAAA9C40, 64'hDEADBEEF00000000};
    fk = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
  endtask

  // Sends words fd/fk (up to n_send of them); pulse_at is the 1-based word carrying the
  // header pulse, 0 for none. The expected outcome is decided here at frame level.
  task automatic send_frame(input int pulse_at, input logic [15:0] et, input logic [31:0] ip,
                            input logic [15:0] port, input bit gaps, input int n_send,
                            output int stalls);
    int  len = fd.size();
    bit  pass;
    bit  rdy;
    int  budget;
    stalls = 0;
    pass = (pulse_at >= 1) && (pulse_at <= len) && (pulse_at <= DEC_LIMIT) && allowed(et, ip, port);
    if (pass) begin
      for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), fk[i], fd[i]});
      mdl_pass++;
    end else begin
      mdl_drop++;
    end
    ethertype = et; dst_ip = ip; dst_port = port;
    for (int i = 0; i < n_send; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        s_axis_tvalid = 1'b0; parsed_valid_pulse = 1'b0;
        @(posedge clk); #1;
      end
      s_axis_tdata = fd[i]; s_axis_tkeep = fk[i]; s_axis_tlast = (i == len - 1);
      s_axis_tvalid = 1'b1; parsed_valid_pulse = (i + 1 == pulse_at);
      budget = 0;
      do begin
        @(negedge clk);
        rdy = s_axis_tready;
        if (!rdy) stalls++;
        @(posedge clk); #1;
        budget++;
      end while (!rdy && budget < 2000);
      if (!rdy) begin
        check("ingress ready timeout", s_axis_tready, 1'b1);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
      end
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; parsed_valid_pulse = 1'b0;
  endtask

  task automatic drain_and_check(input string tag);
    int cyc = 0;
    while (cyc < 5000 && !(exp_q.size() == 0 && pass_cnt == 32'(mdl_pass) &&
                           drop_cnt == 32'(mdl_drop))) begin
      @(posedge clk); cyc++;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check({tag, " pass_cnt"}, pass_cnt, 32'(mdl_pass));
    check({tag, " drop_cnt"}, drop_cnt, 32'(mdl_drop));
    check({tag, " queue empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int st;
    clear_model();
    repeat (3) @(negedge clk);
    check("reset s_tready", s_axis_tready, 1'b0);
    check("reset m_tvalid", m_axis_tvalid, 1'b0);
    check("reset m_tdata/keep/last", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, '0);
    check("reset counters", {pass_cnt, drop_cnt}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post-reset s_tready", s_axis_tready, 1'b1);

    // 1: exact-match rule, UDP frame forwarded
    cfg(0, 1'b1, 32'hC0A80002, 16'h9C40);
    build_udp();
    send_frame(2, 16'h0800, 32'hC0A80002, 16'h9C40, 1'b0, 6, st);
    drain_and_check("t1");

    // 2: empty table, same frame dropped without back-pressure
    do_reset();
    build_udp();
    send_frame(2, 16'h0800, 32'hC0A80002, 16'h9C40, 1'b0, 6, st);
    check("t2 ingress stalls", 32'(st), 32'd0);
    drain_and_check("t2");

    // 3: wildcard port rule
    do_reset();
    cfg(1, 1'b1, 32'hC0A80002, 16'h0000);
    build_udp();
    send_frame(3, 16'h0800, 32'hC0A80002, 16'h1F90, 1'b0, 6, st);
    drain_and_check("t3");

    // 4: pass then drop back-to-back under toggling egress ready
    do_reset();
    cfg(0, 1'b1, 32'hC0A80002, 16'h9C40);
    rdy_mode = 1;
    build_random(9);
    send_frame(2, 16'h0800, 32'hC0A80002, 16'h9C40, 1'b0, 9, st);
    build_random(7);
    send_frame(2, 16'h0800, 32'hC0A80009, 16'h9C40, 1'b0, 7, st);
    drain_and_check("t4");
    rdy_mode = 0;

    // 5: no pulse: short frame dropped at tlast, long non-IP frame dropped at the word limit
    do_reset();
    build_random(3);
    send_frame(0, 16'h0800, 32'hC0A80002, 16'h9C40, 1'b0, 3, st);
    build_random(40);
    send_frame(0, 16'h86DD, 32'h0, 16'h0, 1'b0, 40, st);
    drain_and_check("t5");

    // 6: reset in the middle of a passing frame clears counters and the table
    do_reset();
    cfg(0, 1'b1, 32'hC0A80002, 16'h9C40);
    build_udp();
    send_frame(2, 16'h0800, 32'hC0A80002, 16'h9C40, 1'b0, 3, st);
    rst = 1'b1;
    @(negedge clk);
    check("t6 reset-cycle m_tvalid", m_axis_tvalid, 1'b0);
    check("t6 reset-cycle s_tready", s_axis_tready, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    clear_model();
    @(negedge clk);
    check("t6 m_tvalid after reset", m_axis_tvalid, 1'b0);
    check("t6 counters after reset", {pass_cnt, drop_cnt}, 64'd0);
    build_udp();
    send_frame(2, 16'h0800, 32'hC0A80002, 16'h9C40, 1'b0, 6, st);
    drain_and_check("t6 unprogrammed");
    cfg(0, 1'b1, 32'hC0A80002, 16'h9C40);
    build_udp();
    send_frame(2, 16'h0800, 32'hC0A80002, 16'h9C40, 1'b0, 6, st);
    drain_and_check("t6 reprogrammed");

    // Random traffic against a random table with random egress back-pressure
    begin
      logic [31:0] ip_pool [4] = '{32'hC0A80002, 32'hC0A80003, 32'h0A000001, 32'h0A000002};
      logic [15:0] pt_pool [4] = '{16'h0000, 16'h9C40, 16'h1F90, 16'h0035};
      do_reset();
      for (int r = 0; r < N_RULES; r++)
        cfg(r, 1'($urandom_range(1)), ip_pool[$urandom_range(3)], pt_pool[$urandom_range(3)]);
      rdy_mode = 2;
      for (int f = 0; f < 40; f++) begin
        build_random($urandom_range(1, 40));
        send_frame($urandom_range(0, 7),
                   ($urandom_range(4) == 0) ? 16'h86DD : 16'h0800,
                   ip_pool[$urandom_range(3)],
                   ($urandom_range(1) == 0) ? pt_pool[1 + $urandom_range(2)] : 16'h4321,
                   1'b1, fd.size(), st);
      end
      drain_and_check("random");
      rdy_mode = 0;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
